tlk2711_tx_framer: RTL and testbench
====================================

// Module: tlk2711_tx_framer
// PURPOSE
//   TX data stage downstream of tlk2711_tx_cmd. On i_send_start it consumes the 64-bit MM2S stream that the
//   DMA produces for the issued read command and packs it into framed 16-bit words with K-char flags for
//   the TLK2711 transmit parallel bus. Payload: i_packet_body full frames, then one tail frame of
//   i_packet_tail halfwords (0 = no tail frame).
// PARAMETERS
//   FRAME_HW   256  payload halfwords per full frame (1..65535)
//   IFG_WORDS  4    minimum IDLE words between frames (>=1)
// PORTS
//   i_clk            in   1   single clock, all logic
//   i_rst_n          in   1   asynchronous active-low reset
//   i_soft_rst       in   1   synchronous reset, same effect as i_rst_n
//   i_send_start     in   1   1-cycle start pulse
//   i_packet_body    in   22  number of full frames
//   i_packet_tail    in   10  halfwords in tail frame
//   i_axis_tdata     in   64  DMA MM2S data; halfword 0 = [15:0], sent first
//   i_axis_tvalid    in   1   beat valid
//   o_axis_tready    out  1   beat accepted when tvalid&tready
//   o_tx_data        out  16  TLK2711 TXD
//   o_tx_kmsb        out  1   TXD[15:8] is K-char
//   o_tx_klsb        out  1   TXD[7:0] is K-char
//   o_tx_en          out  1   TLK2711 transmit enable
//   o_busy           out  1   packet in progress
//   o_done           out  1   1-cycle pulse, packet finished
//   o_frame_cnt      out  22  frames sent in current/last packet
//   o_fill_cnt       out  16  mid-frame fill words inserted (saturating)
// BEHAVIOUR
// - Outputs registered. Reset (either): o_tx_data=16'hBC50, kmsb=1, klsb=0, o_tx_en=0, tready=0, busy=0,
//   done=0, counters 0, state IDLE, holding register empty.
// - Words: IDLE 16'hBC50 k=10; SOF 16'hFBFB k=11; EOF 16'hFDFD k=11; all other words k=00.
// - Frame: SOF, NUM (frame index [15:0], 0-based), LEN (payload halfwords), payload, CKSUM, EOF.
//   CKSUM = sum of that frame's payload halfwords mod 2^16.
// - States: IDLE -> SOF -> NUM -> LEN -> PAYLOAD -> CKSUM -> EOF -> GAP -> (SOF | DONE) ; DONE -> IDLE.
//   IDLE: emits IDLE; o_tx_en=1 from first start after reset, else 0. Start with body=0 and tail=0:
//   o_done pulses next cycle, no frame sent. Otherwise busy=1 and SOF appears the cycle after start sampled.
//   GAP: exactly IFG_WORDS IDLE words, then SOF if frames remain else DONE.
//   DONE: one IDLE word, o_done=1, busy=0, then IDLE.
// - Frame order: body frames (LEN=FRAME_HW) first, tail frame (LEN=i_packet_tail) last if tail!=0.
//   body/tail are latched at start; input changes mid-packet are ignored.
// - Stream: one 64-bit holding register. o_axis_tready = busy & holding empty. A beat yields 4 halfwords.
//   When a frame's last payload halfword leaves mid-beat, the rest of that beat is discarded.
//   Frames never share a beat.
// - Underflow: in PAYLOAD with holding empty, emit IDLE (k=10) as fill. Fill words are not counted in LEN,
//   not summed into CKSUM, and increment o_fill_cnt. The fill counter saturates at 16'hFFFF.
// - i_send_start while busy is ignored. o_frame_cnt clears at an accepted start and increments at each EOF.
// - Soft reset mid-frame: frame is truncated (no EOF), state IDLE next cycle, holding register flushed.
// - Widths: frame index wraps at 2^16 in NUM; o_frame_cnt is full 22 bits.
// TESTING
// - body=0,tail=0, start -> o_done 1 cycle later, only 16'hBC50 on bus, no tready.
// - FRAME_HW=8, body=1, tail=0, beats 64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005 ->
//   FBFB,0000,0008,0001..0008,0024,FDFD, then 4 IDLE, then o_done.
// - body=0, tail=5, 2 beats -> LEN=0005, 5 payload halfwords, last 3 halfwords of beat 2 discarded,
//   only 2 beats accepted.
// - body=2, tail=3, FRAME_HW=8 -> NUM 0000/0001/0002, exactly IFG_WORDS IDLE between frames,
//   o_frame_cnt=3 at done.
// - tvalid dropped 3 cycles mid-payload -> 3 IDLE fill words inside frame, CKSUM unchanged, o_fill_cnt=3.
// - i_rst_n low / i_soft_rst mid-payload -> bus IDLE next cycle, busy=0, tready=0, restart yields clean
//   frame NUM=0000.

Source files
------------

// File: rtl/tlk2711_tx_framer.sv
// TLK2711 transmit framer: packs the 64-bit DMA stream into SOF/NUM/LEN/payload/CKSUM/EOF frames
// of 16-bit words with K-char flags, inserting IDLE gaps between frames and IDLE fill on underflow.
module tlk2711_tx_framer #(
    parameter int unsigned FRAME_HW  = 256,
    parameter int unsigned IFG_WORDS = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_soft_rst,
    input  logic        i_send_start,
    input  logic [21:0] i_packet_body,
    input  logic [9:0]  i_packet_tail,
    input  logic [63:0] i_axis_tdata,
    input  logic        i_axis_tvalid,
    output logic        o_axis_tready,
    output logic [15:0] o_tx_data,
    output logic        o_tx_kmsb,
    output logic        o_tx_klsb,
    output logic        o_tx_en,
    output logic        o_busy,
    output logic        o_done,
    output logic [21:0] o_frame_cnt,
    output logic [15:0] o_fill_cnt,
    output logic [3:0]  o_dbg_state
);

    // Stream handshake: a beat transfers on every rising edge where i_axis_tvalid and o_axis_tready
    // are both high; tready is high only while a packet is active and the holding register is empty.

    typedef enum logic [3:0] {
        S_IDLE, S_SOF, S_NUM, S_LEN, S_PAYLOAD, S_CKSUM, S_EOF, S_GAP, S_DONE
    } state_t;

    localparam logic [15:0] IDLE_W    = 16'hBC50;
    localparam logic [15:0] SOF_W     = 16'hFBFB;
    localparam logic [15:0] EOF_W     = 16'hFDFD;
    localparam logic [15:0] FRAME_LEN = 16'(FRAME_HW);
    localparam logic [15:0] GAP_LAST  = 16'(IFG_WORDS);

    state_t      state, state_n;
    logic [21:0] body_q;
    logic [9:0]  tail_q;
    logic [63:0] hold_data;
    logic        hold_valid, hold_valid_n;
    logic [1:0]  hold_ptr, hold_ptr_n, cur_ptr;
    logic        hold_load;
    logic [15:0] hw_cnt, hw_cnt_n;
    logic [15:0] cksum, cksum_n;
    logic [15:0] gap_cnt, gap_cnt_n;
    logic [21:0] frame_cnt_n;
    logic [15:0] fill_cnt_n;
    logic [15:0] word_n, hw;
    logic [1:0]  k_n;
    logic        tx_en_n, busy_n, done_n, tready_n, start_ok;

    logic        accept;
    logic [22:0] total_frames;
    logic        is_body, more_frames, payload_done;
    logic [15:0] cur_len;

    assign accept       = o_axis_tready & i_axis_tvalid;
    assign total_frames = {1'b0, body_q} + {22'd0, (tail_q != 10'd0)};
    assign is_body      = o_frame_cnt < body_q;
    assign more_frames  = {1'b0, o_frame_cnt} < total_frames;
    assign cur_len      = is_body ? FRAME_LEN : {6'd0, tail_q};
    assign payload_done = hw_cnt == cur_len;
    assign o_dbg_state  = 4'(state);

    always_comb begin
        state_n      = state;
        hold_valid_n = hold_valid;
        hold_ptr_n   = hold_ptr;
        hold_load    = 1'b0;
        hw_cnt_n     = hw_cnt;
        cksum_n      = cksum;
        gap_cnt_n    = gap_cnt;
        frame_cnt_n  = o_frame_cnt;
        fill_cnt_n   = o_fill_cnt;
        tx_en_n      = o_tx_en;
        start_ok     = 1'b0;
        word_n       = IDLE_W;
        k_n          = 2'b10;
        hw           = 16'd0;
        cur_ptr      = 2'd0;

        case (state)
            S_IDLE: begin
                if (i_send_start) begin
                    start_ok    = 1'b1;
                    tx_en_n     = 1'b1;
                    frame_cnt_n = 22'd0;
                    state_n     = (i_packet_body == 22'd0 && i_packet_tail == 10'd0) ? S_DONE : S_SOF;
                end
            end
            S_SOF:     state_n = S_NUM;
            S_NUM:     state_n = S_LEN;
            S_LEN:     state_n = S_PAYLOAD;
            S_PAYLOAD: if (payload_done) state_n = S_CKSUM;
            S_CKSUM:   state_n = S_EOF;
            S_EOF:     state_n = S_GAP;
            S_GAP:     if (gap_cnt == GAP_LAST) state_n = more_frames ? S_SOF : S_DONE;
            S_DONE:    state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase

        // A beat accepted outside payload emission is parked whole in the holding register.
        if (accept) begin
            hold_load    = 1'b1;
            hold_valid_n = 1'b1;
            hold_ptr_n   = 2'd0;
        end

        case (state_n)
            S_SOF: begin
                word_n   = SOF_W;
                k_n      = 2'b11;
                hw_cnt_n = 16'd0;
                cksum_n  = 16'd0;
            end
            S_NUM: begin
                word_n = o_frame_cnt[15:0];
                k_n    = 2'b00;
            end
            S_LEN: begin
                word_n = cur_len;
                k_n    = 2'b00;
            end
            S_PAYLOAD: begin
                if (hold_valid || accept) begin
                    // A beat arriving with the register empty feeds its first halfword straight out.
                    cur_ptr  = hold_valid ? hold_ptr : 2'd0;
                    hw       = hold_valid ? hold_data[{hold_ptr, 4'b0000} +: 16] : i_axis_tdata[15:0];
                    word_n   = hw;
                    k_n      = 2'b00;
                    cksum_n  = cksum + hw;
                    hw_cnt_n = hw_cnt + 16'd1;
                    if (hw_cnt_n == cur_len || cur_ptr == 2'd3) begin
                        hold_valid_n = 1'b0;
                        hold_load    = 1'b0;
                    end else begin
                        hold_valid_n = 1'b1;
                        hold_ptr_n   = cur_ptr + 2'd1;
                        hold_load    = !hold_valid;
                    end
                end else begin
                    fill_cnt_n = (o_fill_cnt == 16'hFFFF) ? o_fill_cnt : o_fill_cnt + 16'd1;
                end
            end
            S_CKSUM: begin
                word_n = cksum;
                k_n    = 2'b00;
            end
            S_EOF: begin
                word_n      = EOF_W;
                k_n         = 2'b11;
                frame_cnt_n = o_frame_cnt + 22'd1;
            end
            S_GAP:   gap_cnt_n = (state == S_GAP) ? gap_cnt + 16'd1 : 16'd1;
            default: begin
                hold_valid_n = 1'b0;
                hold_load    = 1'b0;
            end
        endcase

        busy_n = !(state_n == S_IDLE || state_n == S_DONE);
        done_n = state_n == S_DONE;

        if (i_soft_rst) begin
            state_n      = S_IDLE;
            hold_valid_n = 1'b0;
            hold_ptr_n   = 2'd0;
            hold_load    = 1'b0;
            hw_cnt_n     = 16'd0;
            cksum_n      = 16'd0;
            gap_cnt_n    = 16'd0;
            frame_cnt_n  = 22'd0;
            fill_cnt_n   = 16'd0;
            tx_en_n      = 1'b0;
            start_ok     = 1'b0;
            word_n       = IDLE_W;
            k_n          = 2'b10;
            busy_n       = 1'b0;
            done_n       = 1'b0;
        end
        tready_n = busy_n & ~hold_valid_n;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= S_IDLE;
            body_q        <= 22'd0;
            tail_q        <= 10'd0;
            hold_data     <= 64'd0;
            hold_valid    <= 1'b0;
            hold_ptr      <= 2'd0;
            hw_cnt        <= 16'd0;
            cksum         <= 16'd0;
            gap_cnt       <= 16'd0;
            o_frame_cnt   <= 22'd0;
            o_fill_cnt    <= 16'd0;
            o_tx_en       <= 1'b0;
            o_tx_data     <= IDLE_W;
            o_tx_kmsb     <= 1'b1;
            o_tx_klsb     <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_axis_tready <= 1'b0;
        end else begin
            state       <= state_n;
            if (start_ok) begin
                body_q <= i_packet_body;
                tail_q <= i_packet_tail;
            end
            if (hold_load) hold_data <= i_axis_tdata;
            hold_valid    <= hold_valid_n;
            hold_ptr      <= hold_ptr_n;
            hw_cnt        <= hw_cnt_n;
            cksum         <= cksum_n;
            gap_cnt       <= gap_cnt_n;
            o_frame_cnt   <= frame_cnt_n;
            o_fill_cnt    <= fill_cnt_n;
            o_tx_en       <= tx_en_n;
            o_tx_data     <= word_n;
            o_tx_kmsb     <= k_n[1];
            o_tx_klsb     <= k_n[0];
            o_busy        <= busy_n;
            o_done        <= done_n;
            o_axis_tready <= tready_n;
        end
    end

endmodule

// File: tb/tb_tlk2711_tx_framer.sv
// Directed bench for tlk2711_tx_framer (FRAME_HW=8, IFG_WORDS=4): expected bus words are
// hand-computed per frame and compared cycle by cycle.
module tb_tlk2711_tx_framer;

    localparam int IFG = 4;
    localparam logic [17:0] W_IDLE = {2'b10, 16'hBC50};
    localparam logic [17:0] W_SOF  = {2'b11, 16'hFBFB};
    localparam logic [17:0] W_EOF  = {2'b11, 16'hFDFD};
    localparam logic [63:0] B0 = 64'h0004_0003_0002_0001;
    localparam logic [63:0] B1 = 64'h0008_0007_0006_0005;

    logic        i_clk, i_rst_n, i_soft_rst, i_send_start;
    logic [21:0] i_packet_body;
    logic [9:0]  i_packet_tail;
    logic [63:0] i_axis_tdata;
    logic        i_axis_tvalid, o_axis_tready;
    logic [15:0] o_tx_data;
    logic        o_tx_kmsb, o_tx_klsb, o_tx_en, o_busy, o_done;
    logic [21:0] o_frame_cnt;
    logic [15:0] o_fill_cnt;
    logic [3:0]  o_dbg_state;

    tlk2711_tx_framer #(.FRAME_HW(8), .IFG_WORDS(IFG)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_soft_rst(i_soft_rst), .i_send_start(i_send_start),
        .i_packet_body(i_packet_body), .i_packet_tail(i_packet_tail),
        .i_axis_tdata(i_axis_tdata), .i_axis_tvalid(i_axis_tvalid), .o_axis_tready(o_axis_tready),
        .o_tx_data(o_tx_data), .o_tx_kmsb(o_tx_kmsb), .o_tx_klsb(o_tx_klsb), .o_tx_en(o_tx_en),
        .o_busy(o_busy), .o_done(o_done), .o_frame_cnt(o_frame_cnt), .o_fill_cnt(o_fill_cnt),
        .o_dbg_state(o_dbg_state)
    );

    // clock / reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // scoreboard state
    logic [17:0] exp_q[$];
    logic [63:0] beat_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int beats_acc = 0;
    int stall_n = 0;
    int stall_arm = 0;
    int poke_at = -1;
    bit acc_pend = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: retire the beat accepted at the last edge, then drive the stream for the next edge.
    task automatic cycle_step();
        @(negedge i_clk);
        if (acc_pend) begin
            beat_q.delete(0);
            beats_acc++;
            if (stall_arm != 0) begin
                stall_n   = stall_arm;
                stall_arm = 0;
            end
        end
        if (stall_n != 0) begin
            i_axis_tvalid = 1'b0;
            if (o_axis_tready) stall_n--;
        end else begin
            i_axis_tvalid = (beat_q.size() != 0);
            i_axis_tdata  = (beat_q.size() != 0) ? beat_q[0] : 64'd0;
        end
        acc_pend = i_axis_tvalid && o_axis_tready;
    endtask

    task automatic flush();
        beat_q.delete();
        exp_q.delete();
        acc_pend      = 1'b0;
        stall_n       = 0;
        stall_arm     = 0;
        i_axis_tvalid = 1'b0;
    endtask

    task automatic add_frame(input logic [15:0] num, input logic [15:0] len, input logic [15:0] cks,
                             input int nbeats, input logic [63:0] b0, input logic [63:0] b1,
                             input int fill_at, input int fill_n);
        logic [63:0] bw;
        beat_q.push_back(b0);
        if (nbeats > 1) beat_q.push_back(b1);
        exp_q.push_back(W_SOF);
        exp_q.push_back({2'b00, num});
        exp_q.push_back({2'b00, len});
        for (int i = 0; i < int'(len); i++) begin
            if (i == fill_at) for (int f = 0; f < fill_n; f++) exp_q.push_back(W_IDLE);
            bw = (i < 4) ? b0 : b1;
            exp_q.push_back({2'b00, bw[(i % 4) * 16 +: 16]});
        end
        exp_q.push_back({2'b00, cks});
        exp_q.push_back(W_EOF);
        for (int g = 0; g < IFG; g++) exp_q.push_back(W_IDLE);
    endtask

    task automatic start_pulse(input logic [21:0] body, input logic [9:0] tail);
        cycle_step();
        i_send_start  = 1'b1;
        i_packet_body = body;
        i_packet_tail = tail;
        cycle_step();
        i_send_start  = 1'b0;
    endtask

    // Runs one packet, comparing every bus word from the cycle after start through the done cycle.
    task automatic run_packet(input logic [21:0] body, input logic [9:0] tail);
        int n;
        logic [17:0] e;
        beats_acc = 0;
        start_pulse(body, tail);
        n = 0;
        forever begin
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = 18'h3FFFF;
            check("bus_word", 32'({o_tx_kmsb, o_tx_klsb, o_tx_data}), 32'(e));
            if (o_done) break;
            n++;
            if (n > 400) begin
                check("done_timeout", 32'(o_done), 32'd1);
                break;
            end
            cycle_step();
            i_send_start = (n == poke_at);
            if (n == poke_at) begin
                i_packet_body = 22'd7;
                i_packet_tail = 10'd1;
            end
        end
        i_send_start = 1'b0;
        poke_at = -1;
        check("words_left", 32'(exp_q.size()), 32'd0);
        check("busy_at_done", 32'(o_busy), 32'd0);
        check("tready_at_done", 32'(o_axis_tready), 32'd0);
        check("tx_en_at_done", 32'(o_tx_en), 32'd1);
        cycle_step();
        check("done_pulse_end", 32'(o_done), 32'd0);
        check("idle_after_done", 32'({o_tx_kmsb, o_tx_klsb, o_tx_data}), 32'(W_IDLE));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bus"}, 32'({o_tx_kmsb, o_tx_klsb, o_tx_data}), 32'(W_IDLE));
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_tready"}, 32'(o_axis_tready), 32'd0);
        check({tag, "_tx_en"}, 32'(o_tx_en), 32'd0);
        check({tag, "_frame_cnt"}, 32'(o_frame_cnt), 32'd0);
        check({tag, "_fill_cnt"}, 32'(o_fill_cnt), 32'd0);
    endtask

    initial begin
        i_rst_n = 1'b0; i_soft_rst = 1'b0; i_send_start = 1'b0;
        i_packet_body = 22'd0; i_packet_tail = 10'd0;
        i_axis_tdata = 64'd0; i_axis_tvalid = 1'b0;
        repeat (3) @(negedge i_clk);
        check_reset_outputs("reset");
        check("reset_done", 32'(o_done), 32'd0);
        i_rst_n = 1'b1;

        // empty packet: done the next cycle, bus stays IDLE
        exp_q.push_back(W_IDLE);
        run_packet(22'd0, 10'd0);
        check("empty_beats", 32'(beats_acc), 32'd0);

        // one full frame of 1..8
        add_frame(16'h0000, 16'd8, 16'h0024, 2, B0, B1, -1, 0);
        exp_q.push_back(W_IDLE);
        run_packet(22'd1, 10'd0);
        check("one_frame_cnt", 32'(o_frame_cnt), 32'd1);
        check("one_frame_beats", 32'(beats_acc), 32'd2);

        // tail-only frame, last three halfwords of beat 2 discarded
        add_frame(16'h0000, 16'd5, 16'h00F0, 2, 64'h0040_0030_0020_0010, 64'hDEAD_BEEF_CAFE_0050, -1, 0);
        exp_q.push_back(W_IDLE);
        run_packet(22'd0, 10'd5);
        check("tail_beats", 32'(beats_acc), 32'd2);
        check("tail_frame_cnt", 32'(o_frame_cnt), 32'd1);

        // two body frames plus tail, checksum wrap, ignored start mid-packet
        add_frame(16'h0000, 16'd8, 16'h0024, 2, B0, B1, -1, 0);
        add_frame(16'h0001, 16'd8, 16'hFFF8, 2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, -1, 0);
        add_frame(16'h0002, 16'd3, 16'h0600, 1, 64'h9999_0300_0200_0100, 64'd0, -1, 0);
        exp_q.push_back(W_IDLE);
        poke_at = 10;
        run_packet(22'd2, 10'd3);
        check("multi_frame_cnt", 32'(o_frame_cnt), 32'd3);
        check("multi_beats", 32'(beats_acc), 32'd5);
        check("multi_fill_cnt", 32'(o_fill_cnt), 32'd0);

        // underflow: three fill words between beat 1 and beat 2
        stall_arm = 3;
        add_frame(16'h0000, 16'd8, 16'h0024, 2, B0, B1, 4, 3);
        exp_q.push_back(W_IDLE);
        run_packet(22'd1, 10'd0);
        check("fill_cnt", 32'(o_fill_cnt), 32'd3);

        // async reset mid-payload, then a clean restart
        beat_q.push_back(B0);
        beat_q.push_back(B1);
        start_pulse(22'd1, 10'd0);
        repeat (6) cycle_step();
        check("pre_rst_busy", 32'(o_busy), 32'd1);
        i_rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        cycle_step();
        i_rst_n = 1'b1;
        flush();
        add_frame(16'h0000, 16'd8, 16'h0024, 2, B0, B1, -1, 0);
        exp_q.push_back(W_IDLE);
        run_packet(22'd1, 10'd0);

        // soft reset mid-payload, then a clean restart
        beat_q.push_back(B0);
        beat_q.push_back(B1);
        start_pulse(22'd1, 10'd0);
        repeat (6) cycle_step();
        check("pre_soft_busy", 32'(o_busy), 32'd1);
        i_soft_rst = 1'b1;
        cycle_step();
        check_reset_outputs("soft_rst");
        i_soft_rst = 1'b0;
        flush();
        add_frame(16'h0000, 16'd8, 16'h0024, 2, B0, B1, -1, 0);
        exp_q.push_back(W_IDLE);
        run_packet(22'd1, 10'd0);
        check("soft_restart_cnt", 32'(o_frame_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
